hsv2rgb_stream_ctrl: RTL

//  Valid/ready stream controller wrapping the fixed-latency, non-stallable HSV->RGB pipeline.

---
 rtl/hsv2rgb_pkg.sv | 27 ++
 rtl/hsv2rgb_res_fifo.sv | 46 ++++
 rtl/hsv2rgb_stream_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/hsv2rgb_pkg.sv
// hsv2rgb_pkg: shared widths, limits, FSM encoding and input clamp helpers
// for the HSV->RGB stream controller.
package hsv2rgb_pkg;
    localparam int H_W    = 9;
    localparam int S_W    = 9;
    localparam int V_W    = 8;
    localparam int C_W    = 8;
    localparam int WORD_W = 3 * C_W + 2;
    localparam logic [H_W-1:0] H_MAX = 9'd359;
    localparam logic [S_W-1:0] S_MAX = 9'd256;
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_SOF = 2'd1;
    localparam logic [1:0] ST_ACTIVE   = 2'd2;
    localparam logic [1:0] ST_DRAIN    = 2'd3;
    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        WAIT_SOF = ST_WAIT_SOF,
        ACTIVE   = ST_ACTIVE,
        DRAIN    = ST_DRAIN
    } state_e;
    function automatic logic [H_W-1:0] clamp_h(input logic [H_W-1:0] h);
        return (h > H_MAX) ? H_MAX : h;
    endfunction
    function automatic logic [S_W-1:0] clamp_s(input logic [S_W-1:0] s);
        return (s > S_MAX) ? S_MAX : s;
    endfunction
endpackage

// File: rtl/hsv2rgb_res_fifo.sv
// hsv2rgb_res_fifo: synchronous first-word-fall-through FIFO holding RGB+sof+eol
// results; a push into a full FIFO is taken only when a pop frees the slot.
module hsv2rgb_res_fifo
    import hsv2rgb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_push,
    input  logic [WORD_W-1:0]          i_data,
    input  logic                       i_pop,
    output logic [WORD_W-1:0]          o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_count;
    logic              w_push;
    logic              w_pop;
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
    assign o_data  = r_mem[r_rptr];
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/hsv2rgb_stream_ctrl.sv
// hsv2rgb_stream_ctrl: credit-based valid/ready wrapper around a fixed-latency HSV->RGB
// pipeline with frame FSM and geometry check. Optional HSV2RGB_CLAMP_EN clamps h/s before issue.
module hsv2rgb_stream_ctrl
    import hsv2rgb_pkg::*;
#(
    parameter int PIPE_LAT   = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           enable,
    input  logic [H_W-1:0] s_h,
    input  logic [S_W-1:0] s_s,
    input  logic [V_W-1:0] s_v,
    input  logic           s_sof,
    input  logic           s_eol,
    input  logic           s_valid,
    output logic           s_ready,
    output logic [H_W-1:0] p_h,
    output logic [S_W-1:0] p_s,
    output logic [V_W-1:0] p_v,
    output logic           p_de,
    output logic           p_vs,
    output logic           p_hs,
    input  logic [C_W-1:0] p_r,
    input  logic [C_W-1:0] p_g,
    input  logic [C_W-1:0] p_b,
    input  logic           p_rde,
    input  logic           p_rvs,
    input  logic           p_rhs,
    output logic [C_W-1:0] m_r,
    output logic [C_W-1:0] m_g,
    output logic [C_W-1:0] m_b,
    output logic           m_sof,
    output logic           m_eol,
    output logic           m_valid,
    input  logic           m_ready,
    output logic           frame_done,
    output logic           err_geom
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int FW = $clog2(PIPE_LAT + 2);
    logic [1:0]        r_state;
    logic [1:0]        w_state_nx;
    logic [CW-1:0]     r_inflight;
    logic [XW-1:0]     r_col;
    logic [YW-1:0]     r_line;
    logic [FW-1:0]     r_flush;
    logic              r_err;
    logic [CW-1:0]     w_count;
    logic              w_full;
    logic              w_empty;
    logic [WORD_W-1:0] w_rdata;
    logic              w_credit_ok;
    logic              w_acc;
    logic              w_issue;
    logic              w_ret;
    logic              w_pop;
    logic              w_col_last;
    logic              w_line_last;
    logic [H_W-1:0]    w_h;
    logic [S_W-1:0]    w_s;
`ifdef HSV2RGB_CLAMP_EN
    assign w_h = clamp_h(s_h);
    assign w_s = clamp_s(s_s);
`else
    assign w_h = s_h;
    assign w_s = s_s;
`endif
    // Everything issued must fit in the FIFO even if downstream stalls from now on.
    assign w_credit_ok = ~w_full & ((r_inflight + w_count) < CW'(FIFO_DEPTH));
    assign s_ready     = (r_state == ST_WAIT_SOF) | ((r_state == ST_ACTIVE) & w_credit_ok);
    assign w_acc       = s_valid & s_ready;
    assign w_issue     = w_acc & ((r_state == ST_ACTIVE) | s_sof);
    assign w_col_last  = r_col == XW'(IMG_W - 1);
    assign w_line_last = r_line == YW'(IMG_H - 1);
    assign w_ret       = p_rde & (r_flush == '0);
    assign w_pop       = m_valid & m_ready;
    assign m_valid     = ~w_empty;
    assign {m_r, m_g, m_b, m_sof, m_eol} = w_rdata;
    assign frame_done  = (r_state == ST_DRAIN) & (r_inflight == '0) & (w_count == CW'(1)) & w_pop;
    assign err_geom    = r_err;
    assign w_state_nx  = ((r_state == ST_IDLE) & enable) ? ST_WAIT_SOF :
                         (w_issue & s_eol & w_line_last) ? ST_DRAIN :
                         w_issue                         ? ST_ACTIVE :
                         frame_done                      ? (enable ? ST_WAIT_SOF : ST_IDLE) :
                                                           r_state;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_inflight <= '0;
            r_col      <= '0;
            r_line     <= '0;
            r_err      <= 1'b0;
            r_flush    <= FW'(PIPE_LAT + 1);
            p_h        <= '0;
            p_s        <= '0;
            p_v        <= '0;
            p_de       <= 1'b0;
            p_vs       <= 1'b0;
            p_hs       <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_inflight <= r_inflight + CW'(w_issue) - CW'(w_ret);
            r_flush    <= (r_flush != '0) ? r_flush - FW'(1) : r_flush;
            r_err      <= r_err | (w_issue & ((s_eol & ~w_col_last) | ((r_state == ST_ACTIVE) & s_sof)));
            p_de       <= w_issue;
            if (w_issue) begin
                r_col <= (s_eol | w_col_last) ? '0 : r_col + XW'(1);
                if (s_eol) r_line <= w_line_last ? '0 : r_line + YW'(1);
                p_h  <= w_h;
                p_s  <= w_s;
                p_v  <= s_v;
                p_vs <= s_sof;
                p_hs <= s_eol;
            end
        end
    end
    hsv2rgb_res_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_ret),
        .i_data  ({p_r, p_g, p_b, p_rvs, p_rhs}),
        .i_pop   (w_pop),
        .o_data  (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );
endmodule
